// File: rtl/mge_phy_reconfig_rmw_sequencer.sv
// mge_phy_reconfig_rmw_sequencer
// Walks a DPRIO table of {address, mask, value} entries and applies each one
// to the transceiver reconfig Avalon-MM port as a masked read-modify-write.
// Full-mask entries skip the read; zero-mask entries skip the bus entirely.
module mge_phy_reconfig_rmw_sequencer #(
    parameter int RAM_DEPTH      = 7,
    parameter int IDX_W          = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [IDX_W-1:0] rom_index,
    input  logic [25:0]      rom_data,
    output logic [10:0]      reconfig_address,
    output logic             reconfig_read,
    output logic             reconfig_write,
    output logic [31:0]      reconfig_writedata,
    input  logic [31:0]      reconfig_readdata,
    input  logic             reconfig_waitrequest
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_RD,
        S_WR,
        S_NEXT,  // never occupied: its decision is folded into the exits of FETCH and WR
        S_DONE
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RAM_DEPTH - 1);
    localparam logic [15:0]      TO_LAST  = 16'(TIMEOUT_CYCLES - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] rom_index_q, rom_index_d;
    logic [9:0]       addr_q, addr_d;
    logic [7:0]       mask_q, mask_d;
    logic [7:0]       val_q, val_d;
    logic [7:0]       wdata_q, wdata_d;
    logic [15:0]      wait_cnt_q, wait_cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             error_q, error_d;
    logic             read_q, read_d;
    logic             write_q, write_d;

    logic             at_last;
    logic             timeout;
    logic [7:0]       rom_mask;
    logic             unused_readdata_hi;

    assign at_last            = (rom_index_q == LAST_IDX);
    // The stalled cycle that would bring the count to TIMEOUT_CYCLES is the last request cycle.
    assign timeout            = reconfig_waitrequest && (wait_cnt_q == TO_LAST);
    assign rom_mask           = rom_data[15:8];
    assign unused_readdata_hi = ^reconfig_readdata[31:8];

    // Next-state, datapath and registered-output decode for the table walk.
    always_comb begin
        // NOTE: every *_d gets a default before the case so no path leaves one unassigned (no latches).
        state_d     = state_q;
        rom_index_d = rom_index_q;
        addr_d      = addr_q;
        mask_d      = mask_q;
        val_d       = val_q;
        wdata_d     = wdata_q;
        error_d     = error_q;
        wait_cnt_d  = wait_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_FETCH;
                    rom_index_d = '0;
                    error_d     = 1'b0;
                end
            end
            S_FETCH: begin
                addr_d = rom_data[25:16];
                mask_d = rom_mask;
                val_d  = rom_data[7:0];
                if (rom_mask == 8'h00) begin
                    if (at_last) begin
                        state_d = S_DONE;
                    end else begin
                        state_d     = S_FETCH;
                        rom_index_d = rom_index_q + IDX_W'(1);
                    end
                end else if (rom_mask == 8'hFF) begin
                    wdata_d = rom_data[7:0];
                    state_d = S_WR;
                end else begin
                    state_d = S_RD;
                end
            end
            S_RD: begin
                if (!reconfig_waitrequest) begin
                    wdata_d = (reconfig_readdata[7:0] & ~mask_q) | (val_q & mask_q);
                    state_d = S_WR;
                end else if (timeout) begin
                    error_d = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_WR: begin
                if (!reconfig_waitrequest) begin
                    if (at_last) begin
                        state_d = S_DONE;
                    end else begin
                        state_d     = S_FETCH;
                        rom_index_d = rom_index_q + IDX_W'(1);
                    end
                end else if (timeout) begin
                    error_d = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Stall counter restarts with every new transfer and counts its wait cycles.
        if ((state_d == S_RD || state_d == S_WR) && (state_d != state_q)) begin
            wait_cnt_d = '0;
        end else if ((state_q == S_RD || state_q == S_WR) && reconfig_waitrequest) begin
            wait_cnt_d = wait_cnt_q + 16'd1;
        end

        // Outputs are registered decodes of the state being entered.
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_DONE);
        read_d  = (state_d == S_RD);
        write_d = (state_d == S_WR);
    end

    // State and output registers; reset aborts any transfer in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            rom_index_q <= '0;
            addr_q      <= '0;
            mask_q      <= '0;
            val_q       <= '0;
            wdata_q     <= '0;
            wait_cnt_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            read_q      <= 1'b0;
            write_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking here so every flop samples the pre-edge values of the others.
            state_q     <= state_d;
            rom_index_q <= rom_index_d;
            addr_q      <= addr_d;
            mask_q      <= mask_d;
            val_q       <= val_d;
            wdata_q     <= wdata_d;
            wait_cnt_q  <= wait_cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            read_q      <= read_d;
            write_q     <= write_d;
        end
    end

    assign busy               = busy_q;
    assign done               = done_q;
    assign error              = error_q;
    assign rom_index          = rom_index_q;
    assign reconfig_address   = {1'b0, addr_q};
    assign reconfig_read      = read_q;
    assign reconfig_write     = write_q;
    assign reconfig_writedata = {24'h0, wdata_q};

endmodule

// File: doc/mge_phy_reconfig_rmw_sequencer.md
# mge_phy_reconfig_rmw_sequencer

Walks the per-configuration DPRIO table of the 1G/2.5G/10G MGE PHY, one 26-bit entry per step ({address[25:16], bit mask[15:8], value[7:0]}), and applies each entry to the transceiver reconfiguration Avalon-MM port as a masked read-modify-write. It sits directly downstream of the generated reconfig parameter packages: the top level drives `rom_data` from the selected package's `get_ram_data(rom_index)` and sets `RAM_DEPTH` to that package's `ram_depth`. The block issues one `done` pulse per completed sequence. It flags an `error` if the reconfig interface stops responding.

## Interface
- `RAM_DEPTH`, default 7: number of table entries, legal range 1..256.
- `IDX_W`, default `$clog2(RAM_DEPTH)` with a minimum of 1: width of `rom_index`.
- `TIMEOUT_CYCLES`, default 1023: number of consecutive `waitrequest` cycles on one transfer before the transfer is abandoned. Legal range 2..65535.
- `clk`  in  1: the only clock. All logic is synchronous to its rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `start`  in  1: single-cycle request to run the table. Sampled only in IDLE.
- `busy`  out  1: high from the cycle after `start` is accepted through the DONE cycle.
- `done`  out  1: one-cycle pulse when the sequence ends, whether it succeeded or not.
- `error`  out  1: sticky timeout flag. Cleared by the next accepted `start` or by reset.
- `rom_index`  out  IDX_W: index of the current table entry.
- `rom_data`  in  26: table entry for `rom_index`. It is combinational and valid in the same cycle as the index.
- `reconfig_address`  out  11: {1'b0, entry[25:16]}.
- `reconfig_read`  out  1: Avalon-MM read request.
- `reconfig_write`  out  1: Avalon-MM write request.
- `reconfig_writedata`  out  32: write data. Bits [31:8] are always 0.
- `reconfig_readdata`  in  32: read data. Only bits [7:0] are used.
- `reconfig_waitrequest`  in  1: Avalon-MM wait request.

## Operation
- The FSM has six states: IDLE, FETCH, RD, WR, NEXT and DONE.
- IDLE:
  - `start`=1 → FETCH.
  - On entry to FETCH, `rom_index` is set to 0 and `error` is cleared.
- FETCH:
  - Latches `rom_data` into `addr_q`, `mask_q` and `val_q`.
  - `mask_q`=0x00 → NEXT. The entry is skipped with no bus access.
  - `mask_q`=0xFF → WR, with `wdata_q` = `val_q`. No read is issued.
  - Any other mask → RD.
- RD:
  - `reconfig_read`=1.
  - In the cycle where `waitrequest`=0, the read is accepted and `reconfig_readdata[7:0]` is captured as `rd`.
  - `wdata_q` = (`rd` & ~`mask_q`) | (`val_q` & `mask_q`).
  - Then → WR.
- WR:
  - `reconfig_write`=1 with `reconfig_writedata` = {24'h0, `wdata_q`}.
  - When `waitrequest`=0, the write is accepted → NEXT.
- NEXT:
  - This state takes zero cycles: it is folded into the transition leaving WR or FETCH.
  - If `rom_index`=RAM_DEPTH-1 → DONE.
  - Otherwise `rom_index`+1 → FETCH.
  - `rom_index` never wraps.
- DONE: `done`=1 for exactly one cycle → IDLE.
- Timeout:
  - A 16-bit counter is cleared on entry to RD or WR and increments on each cycle with `waitrequest`=1.
  - When the counter reaches TIMEOUT_CYCLES, `read` and `write` drop in the next cycle, `error` is set, and the FSM goes → DONE. The remaining entries are not applied.
- `start` while not in IDLE is ignored. There is no queuing.
- `reconfig_address` and `reconfig_writedata` hold stable for as long as `read` or `write` is asserted and `waitrequest`=1.
- `read` and `write` are never asserted together.
- Reset, including mid-transfer, forces immediately:
  - the FSM to IDLE;
  - `busy`, `done`, `error`, `reconfig_read` and `reconfig_write` to 0;
  - `rom_index`, `reconfig_address` and `reconfig_writedata` to 0.
  - An interrupted write is not completed.

## Timing
- All outputs are registered.
- `start` high in cycle 0 → FETCH and `busy`=1 in cycle 1.
- Per-entry cost with zero wait states:
  - RMW entry: 3 cycles (FETCH, RD, WR).
  - Full-mask entry: 2 cycles (FETCH, WR).
  - Zero-mask entry: 1 cycle (FETCH).
- Each wait-state cycle adds 1 cycle to the entry's cost.
- `done` rises in the cycle after the last write is accepted. `busy` falls in the cycle after `done`.
- For the 7-entry 1.25 Gbps table with zero wait states:
  - Masks are 04, 40, 4F, 0F, 07, 3F, FF.
  - Last write is accepted in cycle 20.
  - `done`=1 in cycle 21.
  - `busy`=1 for cycles 1..21.
- Timeout: with `waitrequest` held high, the request is asserted for exactly TIMEOUT_CYCLES cycles. `done` and `error` follow 1 cycle after the request drops.

## Test plan
- **Single RMW entry.** `rom_data`=26'h1354F42, `readdata`=0xA5, zero wait states → read at address 0x135, then write of 0x000000E2 to 0x135, then `done`.
- **Full-mask entry.** `rom_data`=26'h13BFF28 → no `read` asserted, a single write of 0x28 to 0x13B.
- **Full 7-entry table, zero wait states.**
  - Required: 6 reads, 7 writes, `done` in cycle 21, `error`=0.
  - A mask-0x00 entry inserted into the table causes no bus access for that entry.
- **Wait states.** `waitrequest` high for 5 cycles on every transfer → `address` and `writedata` stable throughout each stall, and `done` delayed by exactly 5 cycles per transfer.
- **Timeout and recovery.**
  - TIMEOUT_CYCLES=16 with `waitrequest` stuck high on the first read → `read` high for 16 cycles, then `error`=1 and a `done` pulse, with no writes issued.
  - A following `start` clears `error`.
- **Start while busy, and reset mid-write.**
  - `start` pulsed while busy → ignored.
  - `reset` asserted during WR with `waitrequest`=1 → all outputs 0 in the same cycle; a new `start` then runs from index 0.
